harakas_absorb_pad: RTL and testbench
=====================================

HARAKAS_ABSORB_PAD -- requirements
Module: harakas_absorb_pad

Interface
REQ-001 The block SHALL have parameter PAD_DS, default 8'h1F, the domain-separation pad byte.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, marking an input message word as valid.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts a word; transfer occurs when in_valid && in_ready.
REQ-006 The block SHALL have port in_data, input, 32, the message word; message byte i of the word is in_data[8i+7:8i].
REQ-007 The block SHALL have port in_last, input, 1, marking the final word of the message.
REQ-008 The block SHALL have port in_nbytes, input, 3, the count of valid bytes in the final word (0..4); it is ignored when in_last=0.
REQ-009 The block SHALL have port out_valid, output, 1, marking a 256-bit rate block as valid toward the Haraka-S permutation core.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the core accepts the block; transfer occurs when out_valid && out_ready.
REQ-011 The block SHALL have port out_data, output, 256, the rate block; block byte j is out_data[8j+7:8j].
REQ-012 The block SHALL have port out_last, output, 1, marking the final (padded) block of the message.

Function
REQ-013 The block SHALL pack accepted words little-endian into a 32-byte buffer, with word k occupying bytes 4k..4k+3.
REQ-014 The block SHALL treat non-last words as carrying 4 bytes, and SHALL treat in_nbytes values 5..7 as 4.
REQ-015 The block SHALL zero the bytes of a final word at or above in_nbytes before they reach out_data.
REQ-016 The FSM SHALL have four states: FILL, EMIT, EMIT_LAST and EMIT_PAD.
REQ-017 in_ready SHALL be 1 only in FILL.
REQ-018 out_valid SHALL be 1 only in EMIT, EMIT_LAST and EMIT_PAD.
REQ-019 In FILL, acceptance of the 8th word with in_last=0 SHALL move the FSM to EMIT, with out_last=0.
REQ-020 In FILL, acceptance of a word with in_last=1 and total message bytes in the current block L<32 SHALL place PAD_DS at byte L, XOR 8'h80 into byte 31, and move the FSM to EMIT_LAST.
REQ-021 When L=31 under REQ-020, byte 31 SHALL equal PAD_DS^8'h80 (8'h9F for the default PAD_DS).
REQ-022 In FILL, acceptance of a word with in_last=1 and L=32 SHALL move the FSM to EMIT with out_last=0, and SHALL set a pending-pad flag.
REQ-023 On a transfer in EMIT with no pad pending, the FSM SHALL go to FILL and clear the buffer and word counter.
REQ-024 On a transfer in EMIT with pad pending, the FSM SHALL go to EMIT_PAD.
REQ-025 In EMIT_PAD, out_data SHALL be byte 0=PAD_DS, byte 31=8'h80, all other bytes 0, with out_last=1.
REQ-026 On a transfer in EMIT_LAST or EMIT_PAD, the FSM SHALL go to FILL with the buffer zeroed and the counter and flag cleared.
REQ-027 Latency: out_valid SHALL assert the cycle after the completing word is accepted.
REQ-028 A final word with in_nbytes=0 at word position 0 of an empty buffer SHALL yield a pad-only block with out_last=1.
REQ-029 While out_valid=1 and out_ready=0, out_data and out_last SHALL be held stable and in_ready SHALL be 0.
REQ-030 in_valid during any emit state SHALL be ignored and SHALL NOT be lost; the upstream must hold it.
REQ-031 out_valid SHALL NOT depend combinationally on out_ready.
REQ-032 in_ready SHALL be registered state-decoded.

Reset
REQ-033 While rst=1 at a clock edge, the block SHALL set state to FILL, clear the buffer to zero, clear the word counter and pending-pad flag, drive out_valid=0 and out_last=0, and drive in_ready=1 from the next cycle.
REQ-034 Reset asserted mid-message or mid-emit SHALL discard all partial data, and no stale byte SHALL appear in any later block.

Structure
REQ-035 The shared package harakas_pkg SHALL hold RATE_BYTES=32, WORD_BYTES=4, PAD_END=8'h80 and the FSM state enum type.
REQ-036 The block SHALL be a single module with no sub-module; the pad/mask logic is a local function.

Verification
REQ-037 The bench SHALL cover: empty message (one beat, in_last=1, in_nbytes=0) -> one block with byte0=8'h1F, byte31=8'h80, rest 0, out_last=1.
REQ-038 The bench SHALL cover: "abc" (in_data=32'h00636261, in_nbytes=3, last) -> bytes 0..2=61,62,63, byte3=1F, byte31=80, out_last=1.
REQ-039 The bench SHALL cover: a 31-byte message (8 beats, last in_nbytes=3) -> a single block with byte31=8'h9F and out_last=1.
REQ-040 The bench SHALL cover: a 32-byte message (8 full beats, last) -> a data block with out_last=0, then a pad-only block (byte0=1F, byte31=80) with out_last=1.
REQ-041 The bench SHALL cover: out_ready held low 5 cycles during EMIT -> out_data constant, in_ready=0, and the next message's first word accepted intact afterwards.
REQ-042 The bench SHALL cover: rst pulsed after 3 words accepted, then "abc" sent -> the block equals the REQ-038 block exactly.

Source files
------------

// File: rtl/harakas_pkg.sv
// Shared constants and FSM state type for the Haraka-S absorb/pad front end.
package harakas_pkg;

    localparam int RATE_BYTES = 32;
    localparam int WORD_BYTES = 4;
    localparam int RATE_W     = 8 * RATE_BYTES;
    localparam int WORDS      = RATE_BYTES / WORD_BYTES;
    localparam logic [7:0] PAD_END = 8'h80;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        EMIT      = 2'd1,
        EMIT_LAST = 2'd2,
        EMIT_PAD  = 2'd3
    } state_e;

endpackage

// File: rtl/harakas_absorb_pad.sv
// Packs 32-bit message words into 256-bit rate blocks and applies the
// domain-separation / 0x80 end padding on the final block of each message.
module harakas_absorb_pad
    import harakas_pkg::*;
#(
    parameter logic [7:0] PAD_DS = 8'h1F
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_data,
    input  logic                in_last,
    input  logic [2:0]          in_nbytes,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RATE_W-1:0]   out_data,
    output logic                out_last
);

    localparam logic [RATE_W-1:0] PAD_BLOCK = {PAD_END, {(RATE_W-16){1'b0}}, PAD_DS};

    // Writes one word into the buffer (bytes at/above nb zeroed) and, for a
    // final word that leaves room, places the pad byte and the closing 0x80.
    function automatic logic [RATE_W-1:0] absorb_word(
        input logic [RATE_W-1:0] blk,
        input logic [2:0]        widx,
        input logic [31:0]       data,
        input logic [2:0]        nb,
        input logic              last,
        input logic [5:0]        len
    );
        logic [RATE_W-1:0] r;
        r = blk;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (k < int'(nb)) r[8*(WORD_BYTES*int'(widx)+k) +: 8] = data[8*k +: 8];
            else              r[8*(WORD_BYTES*int'(widx)+k) +: 8] = 8'h00;
        end
        if (last && (len < 6'd32)) begin
            r[8*int'(len) +: 8] = r[8*int'(len) +: 8] ^ PAD_DS;
            r[RATE_W-1 -: 8]    = r[RATE_W-1 -: 8] ^ PAD_END;
        end
        return r;
    endfunction

    state_e            state_q, state_d;
    logic [RATE_W-1:0] buf_q, buf_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              out_last_q, out_last_d;
    logic              in_ready_q, in_ready_d;
    logic [2:0]        nb_eff;
    logic [5:0]        len;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        out_last_d = out_last_q;
        nb_eff     = (!in_last || (in_nbytes > 3'd4)) ? 3'd4 : in_nbytes;
        len        = {1'b0, cnt_q, 2'b00} + {3'b000, nb_eff};

        unique case (state_q)
            FILL: begin
                if (in_valid && in_ready_q) begin
                    buf_d = absorb_word(buf_q, cnt_q, in_data, nb_eff, in_last, len);
                    if (in_last) begin
                        if (len < 6'd32) begin
                            state_d    = EMIT_LAST;
                            out_last_d = 1'b1;
                        end else begin
                            state_d = EMIT;
                            pend_d  = 1'b1;
                        end
                    end else if (cnt_q == 3'(WORDS-1)) begin
                        state_d = EMIT;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (pend_q) begin
                        state_d    = EMIT_PAD;
                        buf_d      = PAD_BLOCK;
                        pend_d     = 1'b0;
                        out_last_d = 1'b1;
                    end else begin
                        state_d = FILL;
                        buf_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            EMIT_LAST, EMIT_PAD: begin
                if (out_ready) begin
                    state_d    = FILL;
                    buf_d      = '0;
                    cnt_d      = '0;
                    pend_d     = 1'b0;
                    out_last_d = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase

        in_ready_d = (state_d == FILL);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q    <= FILL;
            // NOTE: the rate buffer is reset too, so a reset mid-message can never leak stale bytes.
            buf_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            out_last_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            out_last_q <= out_last_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != FILL);
    assign out_data  = buf_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_harakas_absorb_pad.sv
// Directed bench: a byte-level padding model predicts every rate block, and a
// compare process checks each handshake plus hold-stability under backpressure.
module tb_harakas_absorb_pad;

    localparam logic [7:0] PAD = 8'h1F;

    typedef logic [7:0] bq_t[$];

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic [2:0]   in_nbytes = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [255:0] out_data;
    logic         out_last;

    int n_checks = 0;
    int n_pass   = 0;

    logic [256:0] exp_q[$];

    harakas_absorb_pad #(.PAD_DS(PAD)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_nbytes (in_nbytes),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [256:0] act, input logic [256:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: message || PAD || zeros to a 32-byte multiple, last byte ^= 0x80.
    task automatic model_push(input bq_t msg);
        bq_t p;
        logic [255:0] blk;
        int nblk;
        p = msg;
        p.push_back(PAD);
        while (p.size() % 32 != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] ^ 8'h80;
        nblk = p.size() / 32;
        for (int b = 0; b < nblk; b++) begin
            for (int j = 0; j < 32; j++) blk[8*j +: 8] = p[32*b+j];
            exp_q.push_back({(b == nblk-1), blk});
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int budget;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        in_nbytes = nb;
        budget    = 0;
        while (!in_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("in_ready_wait", {256'b0, in_ready}, 257'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
    endtask

    // Unused bytes of the final word carry 'fill'; a full final word uses last_nb.
    task automatic send_msg(input bq_t msg, input logic [7:0] fill, input logic [2:0] last_nb);
        int len, nw, nb;
        logic [31:0] d;
        len = msg.size();
        nw  = (len == 0) ? 1 : (len + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            nb = len - 4*w;
            if (nb > 4) nb = 4;
            for (int i = 0; i < 4; i++) d[8*i +: 8] = (i < nb) ? msg[4*w+i] : fill;
            if (w == nw-1) send_word(d, 1'b1, (nb == 4) ? last_nb : 3'(nb));
            else           send_word(d, 1'b0, 3'd1);
        end
        check("latency_out_valid", {256'b0, out_valid}, 257'd1);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("drain_blocks", 257'(exp_q.size()), 257'd0);
        @(negedge clk);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {256'b0, out_valid}, 257'd0);
        check("rst_out_last", {256'b0, out_last}, 257'd0);
        rst = 1'b0;
        exp_q.delete();
        check("rst_in_ready", {256'b0, in_ready}, 257'd1);
    endtask

    // Compare process: sampled mid-low-phase, well away from the rising edge.
    logic         prev_valid = 1'b0;
    logic         prev_ready = 1'b0;
    logic [256:0] prev_blk   = '0;
    always begin
        logic [256:0] exp;
        @(negedge clk);
        #2;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                check("in_ready_while_emit", {256'b0, in_ready}, 257'd0);
                if (prev_valid && !prev_ready)
                    check("hold_stable", {out_last, out_data}, prev_blk);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_block", {out_last, out_data}, 257'd0);
                    end else begin
                        exp = exp_q.pop_front();
                        check("block", {out_last, out_data}, exp);
                    end
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_blk   = {out_last, out_data};
        end
    end

    initial begin
        bq_t m;
        repeat (2) @(negedge clk);
        pulse_rst();

        // Empty message: pad-only block.
        m = {};
        model_push(m);
        check("pin_empty", exp_q[0], {1'b1, 8'h80, 240'h0, 8'h1F});
        send_msg(m, 8'hAA, 3'd4);
        drain();

        // "abc".
        m = {8'h61, 8'h62, 8'h63};
        model_push(m);
        check("pin_abc", exp_q[0], {1'b1, 8'h80, 216'h0, 32'h1F636261});
        send_msg(m, 8'h00, 3'd4);
        drain();

        // 31 bytes: pad and end marker share byte 31.
        m = {};
        for (int i = 0; i < 31; i++) m.push_back(8'(i + 1));
        model_push(m);
        check("pin_31_byte31", {249'b0, exp_q[0][256], exp_q[0][255:248]}, {249'b0, 1'b1, 8'h9F});
        send_msg(m, 8'hEE, 3'd4);
        drain();

        // 32 bytes with final in_nbytes=7 (treated as 4), 5-cycle stall on the data block.
        m = {};
        for (int i = 0; i < 32; i++) m.push_back(8'(8'hC0 + i));
        model_push(m);
        check("pin_32_blocks", 257'(exp_q.size()), 257'd2);
        check("pin_32_pad", exp_q[1], {1'b1, 8'h80, 240'h0, 8'h1F});
        check("pin_32_data_last", {256'b0, exp_q[0][256]}, 257'd0);
        out_ready = 1'b0;
        send_msg(m, 8'hEE, 3'd7);
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        drain();

        // Next message after the stall arrives intact; 37 bytes spans two blocks.
        m = {};
        for (int i = 0; i < 37; i++) m.push_back(8'(8'h30 + 3*i));
        model_push(m);
        send_msg(m, 8'h5A, 3'd4);
        drain();

        // Reset while a data block is held by backpressure.
        m = {};
        for (int i = 0; i < 32; i++) m.push_back(8'hA5);
        out_ready = 1'b0;
        send_msg(m, 8'h00, 3'd4);
        repeat (2) @(negedge clk);
        pulse_rst();
        out_ready = 1'b1;

        // Reset after three accepted words, then "abc" must match exactly.
        send_word(32'h1111_1111, 1'b0, 3'd4);
        send_word(32'h2222_2222, 1'b0, 3'd4);
        send_word(32'h3333_3333, 1'b0, 3'd4);
        pulse_rst();
        m = {8'h61, 8'h62, 8'h63};
        model_push(m);
        check("pin_abc_after_rst", exp_q[0], {1'b1, 8'h80, 216'h0, 32'h1F636261});
        send_msg(m, 8'h00, 3'd4);
        drain();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
